mac_vector_engine: RTL and testbench
====================================

// Module: mac_vector_engine
// PURPOSE
//   Multi-lane, pipelined MAC: accepts LANES data/weight pairs per beat and sums all lane products.
//   Accumulates over a programmed number of beats (len), then holds one dot-product result under a valid/ready handshake.
//   Next-generation compute element for the accelerator datapath; replaces the single-lane MAC in dot-product loops.
// PARAMETERS
//   LANES        4   parallel multiply lanes per beat
//   DATA_WIDTH   16  signed activation width per lane
//   WEIGHT_WIDTH 8   signed weight width per lane
//   ACCUM_WIDTH  32  signed accumulator/result width
//   LEN_WIDTH    8   width of beat-count input (max 2**LEN_WIDTH-1 beats)
// PORTS
//   clk        in   1                    clock, rising edge
//   rst_n      in   1                    asynchronous active-low reset
//   start      in   1                    begin a job; sampled only in IDLE
//   len        in   LEN_WIDTH            beats in this job; latched on accepted start
//   in_valid   in   1                    beat valid
//   in_ready   out  1                    engine accepts beat
//   data_in    in   LANES*DATA_WIDTH     lane i at [i*DATA_WIDTH +: DATA_WIDTH], signed
//   weight_in  in   LANES*WEIGHT_WIDTH   lane i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH], signed
//   res_valid  out  1                    result available
//   res_ready  in   1                    consumer takes result
//   res_data   out  ACCUM_WIDTH          signed dot-product result
//   overflow   out  1                    sticky saturation flag for current job
//   busy       out  1                    high in any state other than IDLE
// BEHAVIOUR
//   Reset: single clock domain; reset asynchronous, active-low. All outputs 0, FSM to IDLE, pipeline valid bits and accumulator cleared.
//   Reset mid-job: the job is discarded; no result is produced.
//   FSM: IDLE -> LOAD on start with len!=0. Latch len into beat counter and clear accumulator and overflow.
//        IDLE -> DONE on start with len==0. Set res_data=0; res_valid is high on the next cycle.
//        LOAD: in_ready=1; each in_valid&&in_ready beat decrements the counter. The last beat moves the FSM to DRAIN.
//        DRAIN: wait until the pipeline is empty (2 cycles), then DONE.
//        DONE: res_valid=1; res_data and overflow are held stable until res_valid&&res_ready, then IDLE.
//   start outside IDLE is ignored. in_ready is 0 outside LOAD. Gaps in in_valid during LOAD are allowed and stall nothing.
//   Pipeline: S1 registers LANES signed products (DATA_WIDTH+WEIGHT_WIDTH bits each).
//     S2 registers the lane sum, sign-extended to ACCUM_WIDTH. S3 adds it into the accumulator.
//     Latency: res_valid rises exactly 3 cycles after the last beat handshake.
//   Arithmetic: all operands signed two's complement.
//     Lane sum is computed at ACCUM_WIDTH bits (ACCUM_WIDTH >= DATA_WIDTH+WEIGHT_WIDTH+clog2(LANES)).
//     Accumulator behaviour on overflow is set by the macro below.
//   Back-to-back: a new start is accepted no earlier than the cycle after the result handshake (IDLE).
// CONFIGURATION
//   MAC_VEC_SATURATE_EN defined:
//     each accumulate step clamps to +(2**(ACCUM_WIDTH-1)-1) or -(2**(ACCUM_WIDTH-1)).
//     On any clamp, overflow is set and stays set until the next accepted start.
//   Undefined: accumulator wraps modulo 2**ACCUM_WIDTH; overflow is tied to 0.
// STRUCTURE
//   mac_vec_pkg: state enum (IDLE, LOAD, DRAIN, DONE), pipeline depth localparam (3), function sat_add() for the saturating sum.
//   Sub-module mac_lane_mult: one registered signed multiplier (S1), instantiated LANES times via generate.
//   The lane adder tree, accumulator and FSM live in mac_vector_engine.
// TESTING
//   1 len=1, data {1,2,3,4}, weight {5,6,7,8}
//     -> res_data=70; res_valid 3 cycles after the beat; overflow=0.
//   2 len=3, in_valid with 1-cycle gaps, every lane data=1, weight=2
//     -> res_data=24; in_ready drops after the 3rd beat.
//   3 len=2, every lane data=-3, weight=8'hFE -> res_data=48.
//     Then len=1, data {6,0,0,0}, weight {8'hFE,0,0,0} -> res_data=-12.
//   4 Hold res_ready=0 for 5 cycles in DONE, pulsing start
//     -> res_data stable, in_ready=0, start ignored; result accepted on the res_ready cycle, then busy=0.
//   5 len=0 start -> res_valid the next cycle with res_data=0; no beat is accepted.
//   6 len=255, every lane data=16'h7FFF, weight=8'h7F
//     -> with MAC_VEC_SATURATE_EN: res_data=32'h7FFFFFFF, overflow=1.
//     -> without: res_data = 255*4*4161409 mod 2**32, overflow=0.
//   7 rst_n low for 1 cycle mid-LOAD after 2 beats
//     -> all outputs 0; then a fresh len=1 job returns the correct result with no residue from the aborted job.

Source files
------------

// File: rtl/mac_vec_pkg.sv
// Shared types and helpers for the multi-lane MAC vector engine.
//   state_t    : job FSM states
//   PIPE_DEPTH : product -> lane sum -> accumulate
//   sat_add()  : signed add clamped to a w-bit two's-complement range
//                (w < SAT_W); operands are passed sign-extended to SAT_W.
package mac_vec_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int PIPE_DEPTH = 3;
  localparam int SAT_W      = 64;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] sum;
  } sat_t;

  function automatic sat_t sat_add(input logic [SAT_W-1:0] a,
                                   input logic [SAT_W-1:0] b,
                                   input int               w);
    sat_t                    r;
    logic signed [SAT_W:0]   s, one, mx, mn;
    one   = (SAT_W+1)'(1);
    s     = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    mx    = (one <<< (w - 1)) - one;
    mn    = -mx - one;
    r.ovf = 1'b0;
    r.sum = SAT_W'(s);
    if (s > mx) begin
      r.ovf = 1'b1;
      r.sum = SAT_W'(mx);
    end else if (s < mn) begin
      r.ovf = 1'b1;
      r.sum = SAT_W'(mn);
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One registered signed multiplier lane (pipeline stage 1).
//   clk, rst_n : clock / async active-low reset
//   en         : capture a new product this cycle
//   a, w       : signed activation and weight
//   p          : registered signed product, DW+WW bits
module mac_lane_mult #(
  parameter int DW = 16,
  parameter int WW = 8,
  localparam int PW = DW + WW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [WW-1:0] w,
  output logic signed [PW-1:0] p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  p <= '0;
    else if (en) p <= PW'(a) * PW'(w);
  end

endmodule

// File: rtl/mac_vector_engine.sv
// Multi-lane pipelined dot-product engine.
// Accepts LANES data/weight pairs per beat for len beats, sums all lane
// products into a signed accumulator, then holds the result under
// res_valid/res_ready.
//   start/len          : job launch (IDLE only); len==0 gives result 0
//   in_valid/in_ready  : beat handshake, in_ready high only in LOAD
//   data_in/weight_in  : packed signed lanes, lane i at [i*W +: W]
//   res_valid/ready    : result handshake, res_data/overflow held in DONE
//   overflow           : sticky clamp flag for the current job
//   busy               : any state other than IDLE
// Build option MAC_VEC_SATURATE_EN: saturating accumulate with sticky
// overflow; otherwise the accumulator wraps and overflow stays 0.
module mac_vector_engine
  import mac_vec_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in,
  input  logic [LANES*WEIGHT_WIDTH-1:0] weight_in,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ACCUM_WIDTH-1:0]        res_data,
  output logic                          overflow,
  output logic                          busy
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  // Stage 3 writes the accumulator itself, so only stages 0..2 need a
  // valid bit: [0] beat accepted now, [1] products valid, [2] lane sum valid.
  localparam int VLD_STAGES = PIPE_DEPTH - 1;

  state_t                         state, state_nx;
  logic [LEN_WIDTH-1:0]           cnt;
  logic [VLD_STAGES:0]            vld_pipe;
  logic [LANES-1:0][PW-1:0]       prod;
  logic signed [ACCUM_WIDTH-1:0]  lane_sum, s2_sum, acc, acc_step;
  logic                           ovf_q, step_ovf;
  logic                           beat, start_ok;

  assign in_ready    = (state == LOAD);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign res_data    = acc;
  assign overflow    = ovf_q;
  assign beat        = in_valid && in_ready;
  assign start_ok    = start && (state == IDLE);
  assign vld_pipe[0] = beat;

  // S1: one registered multiplier per lane
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane_mult #(.DW(DATA_WIDTH), .WW(WEIGHT_WIDTH)) u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (beat),
      .a     (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .w     (weight_in[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
      .p     (prod[g])
    );
  end

  // Lane sum at full accumulator width so it can never wrap
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + ACCUM_WIDTH'($signed(prod[i]));
  end

`ifdef MAC_VEC_SATURATE_EN
  sat_t sr;
  always_comb begin
    sr       = sat_add(SAT_W'(acc), SAT_W'(s2_sum), ACCUM_WIDTH);
    acc_step = ACCUM_WIDTH'(sr.sum);
    step_ovf = sr.ovf;
  end
`else
  always_comb begin
    acc_step = acc + s2_sum;
    step_ovf = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[VLD_STAGES:1] <= '0;
      s2_sum                 <= '0;
      acc                    <= '0;
      ovf_q                  <= 1'b0;
      cnt                    <= '0;
    end else begin
      vld_pipe[VLD_STAGES:1] <= vld_pipe[VLD_STAGES-1:0];
      if (vld_pipe[1]) s2_sum <= lane_sum;
      // Pipeline is always empty in IDLE, so a start never races S3.
      if (start_ok) begin
        acc   <= '0;
        ovf_q <= 1'b0;
        cnt   <= len;
      end else begin
        if (vld_pipe[2]) begin
          acc <= acc_step;
          if (step_ovf) ovf_q <= 1'b1;
        end
        if (beat) cnt <= cnt - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (len == '0) ? DONE : LOAD;
      LOAD:  if (beat && cnt == LEN_WIDTH'(1)) state_nx = DRAIN;
      // Leave once S1 is empty: the last sum is in S2 and lands in the
      // accumulator on the same edge that enters DONE.
      DRAIN: if (!vld_pipe[1]) state_nx = DONE;
      DONE:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_vector_engine.sv
module tb_mac_vector_engine;

  localparam int LANES = 4, DW = 16, WW = 8, AW = 32, LW = 8;

  logic                  clk, rst_n, start, in_valid, in_ready;
  logic [LW-1:0]         len;
  logic [LANES*DW-1:0]   data_in;
  logic [LANES*WW-1:0]   weight_in;
  logic                  res_valid, res_ready, overflow, busy;
  logic [AW-1:0]         res_data;

  mac_vector_engine #(.LANES(LANES), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
                      .ACCUM_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    longint data;
    bit     ovf;
    int     lat;
  } exp_t;

  exp_t   sbq[$];
  int     n_pass = 0, n_chk = 0;
  int     last_hs = 0;
  int     bd[256][LANES];
  int     bw[256][LANES];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: dot product over all beats with 64-bit integers; clamping
  // (when enabled) is applied after every beat, wrapping to 32 bits at the end.
  function automatic exp_t model(input int n);
    exp_t   e;
    longint acc = 0, s;
    bit     ov = 0;
    longint mx = 64'sd2147483647, mn = -64'sd2147483648;
    for (int b = 0; b < n; b++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) s += longint'(bd[b][l]) * longint'(bw[b][l]);
      acc += s;
`ifdef MAC_VEC_SATURATE_EN
      if (acc > mx) begin acc = mx; ov = 1; end
      else if (acc < mn) begin acc = mn; ov = 1; end
`endif
    end
    e.data = acc & 64'hFFFF_FFFF;
    e.ovf  = ov;
    e.lat  = (n == 0) ? 1 : 3;
    return e;
  endfunction

  // Monitor: pops the scoreboard on each new result, checks hold behaviour
  // while the result waits and the return to IDLE after it is taken.
  initial begin
    bit     pv = 0, ph = 0, ho = 0;
    longint hd = 0;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; ph = 0;
      end else begin
        if (ph) begin
          check("post_accept_busy", busy, 0);
          check("post_accept_valid", res_valid, 0);
        end else if (pv) begin
          check("hold_valid", res_valid, 1);
          check("hold_data", longint'(res_data), hd);
          check("hold_ovf", overflow, longint'(ho));
          check("hold_in_ready", in_ready, 0);
        end
        if (res_valid && !pv) begin
          if (sbq.size() == 0) check("unexpected_result", 1, 0);
          else begin
            e = sbq.pop_front();
            check("res_data", longint'(res_data), e.data);
            check("overflow", overflow, longint'(e.ovf));
            check("latency", ncyc - last_hs, e.lat);
          end
          hd = longint'(res_data);
          ho = overflow;
        end
        pv = res_valid;
        ph = res_valid && res_ready;
      end
    end
  end

  task automatic drive_beat(input int b);
    in_valid = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      data_in[l*DW +: DW]   = DW'(bd[b][l]);
      weight_in[l*WW +: WW] = WW'(bw[b][l]);
    end
  endtask

  task automatic run_job(input int n, input int gap, input int hold);
    exp_t e;
    bit   ok;
    int   t;
    e = model(n);
    sbq.push_back(e);
    res_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(n);
    @(negedge clk);
    check("start_in_idle", busy, 0);
    if (n == 0) last_hs = ncyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (n == 0) begin
      in_valid = 1'b1;
      check("len0_no_beat", in_ready, 0);
      in_valid = 1'b0;
    end
    for (int b = 0; b < n; b++) begin
      if (b > 0 && gap != 0) begin
        int g = (gap == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (g) begin in_valid = 1'b0; @(posedge clk); #1; end
      end
      drive_beat(b);
      t = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        if (ok) last_hs = ncyc;
        @(posedge clk); #1;
        t++;
      end while (!ok && t < 10);
      if (!ok) begin check("beat_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
    if (n > 0) begin
      @(negedge clk);
      check("in_ready_drop", in_ready, 0);
    end
    t = 0;
    while (!res_valid && t < 20) begin @(negedge clk); t++; end
    if (!res_valid) check("result_timeout", 0, 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start = ~start; len = 3;
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_accept", busy, 0);
  endtask

  task automatic fill_const(input int n, input int d, input int w);
    for (int b = 0; b < n; b++)
      for (int l = 0; l < LANES; l++) begin bd[b][l] = d; bw[b][l] = w; end
  endtask

  task automatic fill_rand(input int n);
    for (int b = 0; b < n; b++)
      for (int l = 0; l < LANES; l++) begin
        bd[b][l] = int'($urandom_range(0, 65535)) - 32768;
        bw[b][l] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  initial begin
    rst_n = 0; start = 0; len = '0; in_valid = 0;
    data_in = '0; weight_in = '0; res_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", longint'(res_data), 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // single beat: 1*5+2*6+3*7+4*8 = 70
    bd[0] = '{1, 2, 3, 4}; bw[0] = '{5, 6, 7, 8};
    run_job(1, 0, 0);
    // three beats with gaps: 3*4*2 = 24
    fill_const(3, 1, 2);
    run_job(3, 1, 0);
    // negative operands: 2*4*(-3*-2) = 48, then 6*-2 = -12
    fill_const(2, -3, -2);
    run_job(2, 0, 0);
    fill_const(1, 0, 0);
    bd[0][0] = 6; bw[0][0] = -2;
    run_job(1, 0, 0);
    // result held under back-pressure while start pulses
    fill_rand(2);
    run_job(2, 0, 5);
    // empty job
    run_job(0, 0, 0);
    // positive and negative overflow over the full length
    fill_const(255, 32767, 127);
    run_job(255, 0, 0);
    fill_const(255, -32768, 127);
    run_job(255, 0, 0);

    // reset mid-LOAD after two beats: no result may appear
    fill_const(5, 1000, 100);
    @(posedge clk); #1;
    start = 1; len = 5;
    @(posedge clk); #1;
    start = 0;
    for (int b = 0; b < 2; b++) begin drive_beat(b); @(posedge clk); #1; end
    in_valid = 0;
    rst_n = 0;
    @(negedge clk);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_data", longint'(res_data), 0);
    check("abort_overflow", overflow, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    fill_rand(1);
    run_job(1, 0, 0);

    // randomized jobs
    for (int k = 0; k < 14; k++) begin
      int n = (k == 7) ? 0 : int'($urandom_range(1, 12));
      fill_rand(n);
      run_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
